// File: rtl/demux_tdm_driver.sv
// Time-division driver for a 1-to-4 demux: sends a 4-bit word one channel at a time.
// Optional macro DEMUX_TDM_BACK2BACK_EN accepts the next word during the final dwell cycle.
module demux_tdm_driver #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [3:0] in_mask,
    output logic       D,
    output logic [1:0] S,
    output logic       busy,
    output logic       done
);
    localparam int CW = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [1:0]    s_q, s_d;
    logic          d_q, d_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          in_ready_q, in_ready_d;
    logic [3:0]    data_q, data_d;
    logic [3:0]    mask_q, mask_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef DEMUX_TDM_BACK2BACK_EN
    logic          pend_q, pend_d;
`endif

    logic       hs;
    logic       start;
    logic       last_cyc;
    logic       has_nxt;
    logic [1:0] nxt_ch;
    logic [1:0] first_ch;

    function automatic logic any_from(input logic [3:0] m, input int from);
        any_from = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i >= from && m[i]) any_from = 1'b1;
    endfunction

    // lowest enabled channel at or above 'from'
    function automatic logic [1:0] low_from(input logic [3:0] m, input int from);
        low_from = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (i >= from && m[i]) low_from = 2'(i);
    endfunction

    always_comb begin
        hs       = in_valid && in_ready_q;
        first_ch = low_from(in_mask, 0);
        nxt_ch   = low_from(mask_q, int'(s_q) + 1);
        has_nxt  = any_from(mask_q, int'(s_q) + 1);
        last_cyc = (cnt_q == LAST);
        start    = 1'b0;
        state_d  = state_q;
        s_d      = s_q;
        d_d      = d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        data_d   = data_q;
        mask_d   = mask_q;
`ifdef DEMUX_TDM_BACK2BACK_EN
        pend_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                d_d    = 1'b0;
                busy_d = 1'b0;
`ifdef DEMUX_TDM_BACK2BACK_EN
                if (pend_q) done_d = 1'b1;
`endif
                if (hs) begin
                    if (in_mask != 4'd0) start = 1'b1;
                    else done_d = 1'b1;
                end
            end
            SEND: begin
                if (!last_cyc) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (has_nxt) begin
                    s_d   = nxt_ch;
                    d_d   = data_q[nxt_ch];
                    cnt_d = '0;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    d_d     = 1'b0;
`ifdef DEMUX_TDM_BACK2BACK_EN
                    if (hs) begin
                        if (in_mask != 4'd0) start = 1'b1;
                        else pend_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = SEND;
            s_d     = first_ch;
            d_d     = in_data[first_ch];
            busy_d  = 1'b1;
            cnt_d   = '0;
            data_d  = in_data;
            mask_d  = in_mask;
        end
        // ready is registered, so it is derived from the state of the coming cycle
`ifdef DEMUX_TDM_BACK2BACK_EN
        in_ready_d = (state_d == IDLE) ||
                     (cnt_d == LAST && !any_from(mask_d, int'(s_d) + 1));
`else
        in_ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= 2'd0;
            d_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
            data_q     <= 4'd0;
            mask_q     <= 4'd0;
            cnt_q      <= '0;
`ifdef DEMUX_TDM_BACK2BACK_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
`ifdef DEMUX_TDM_BACK2BACK_EN
            pend_q     <= pend_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign D        = d_q;
    assign S        = s_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule
